// File: rtl/decode_stage.sv
// decode_stage: single-entry decode/register-read pipeline stage.
//
// Decodes the fetch slot into ControlUnit control bits and a sign-extended
// immediate, reads two operands from an NREG x XLEN register file and
// captures everything into one output register handed to EX.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid_in/idata/pc  fetch slot; id_ready_out = slot accepted this cycle
//   id_flush_in         EX redirect, squashes the stage
//   ex_ready_in         EX consumes the output register this cycle
//   wb_reg_wr_in/rd/data  writeback write port
//   id_valid_out, id_ctrl_out, id_rv1/rv2/imm/pc_out, id_rd_out, id_func3_out
//                       registered decode results
//   id_dbg_out          combinational contents of register DBG_REG
//
// Control word {alu_src, alu_op, branch, reginsel, dwe, mem_reg, reg_wr}:
//   OP      alu_op={f7[5],f3}, reg_wr
//   OP-IMM  alu_src=01, alu_op={f7[5]&(f3==101),f3}, reg_wr
//   LOAD    alu_src=01, mem_reg, reg_wr
//   STORE   alu_src=01, dwe=0001/0011/1111 for byte/half/word
//   BRANCH  branch=01
//   JAL     branch=10, reginsel=01 (pc+4), reg_wr
//   JALR    branch=11, alu_src=01, reginsel=01, reg_wr
//   LUI     alu_src=01, reginsel=10 (imm), reg_wr
//   AUIPC   alu_src=11 (pc+imm), reg_wr
//   other   all zero
//
// Optional macro DECODE_WB_BYPASS_EN: operand reads see a same-cycle
// writeback; without it they return the pre-write register value.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int DBG_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_in,
  input  logic [31:0]     id_idata_in,
  input  logic [XLEN-1:0] id_pc_in,
  output logic            id_ready_out,
  input  logic            id_flush_in,
  input  logic            ex_ready_in,
  input  logic            wb_reg_wr_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic            id_valid_out,
  output logic [15:0]     id_ctrl_out,
  output logic [XLEN-1:0] id_rv1_out,
  output logic [XLEN-1:0] id_rv2_out,
  output logic [XLEN-1:0] id_imm_out,
  output logic [XLEN-1:0] id_pc_out,
  output logic [4:0]      id_rd_out,
  output logic [2:0]      id_func3_out,
  output logic [XLEN-1:0] id_dbg_out
);
  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic [1:0] alu_src;
    logic [3:0] alu_op;
    logic [1:0] branch;
    logic [1:0] reginsel;
    logic [3:0] dwe;
    logic       mem_reg;
    logic       reg_wr;
  } ctrl_t;

  logic [XLEN-1:0] rf [NREG];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  ctrl_t       ctl;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm, rv1_raw, rv2_raw, rv1, rv2;
  logic        wb_we, hazard, load;

  assign opc = id_idata_in[6:0];
  assign f3  = id_idata_in[14:12];
  assign rs1 = id_idata_in[19:15];
  assign rs2 = id_idata_in[24:20];

  always_comb begin
    ctl   = '0;
    imm32 = '0;
    case (opc)
      7'b0110011: begin
        ctl.alu_op = {id_idata_in[30], f3};
        ctl.reg_wr = 1'b1;
      end
      7'b0010011: begin
        ctl.alu_src = 2'b01;
        ctl.alu_op  = {id_idata_in[30] & (f3 == 3'b101), f3};
        ctl.reg_wr  = 1'b1;
        imm32       = {{20{id_idata_in[31]}}, id_idata_in[31:20]};
      end
      7'b0000011: begin
        ctl.alu_src = 2'b01;
        ctl.mem_reg = 1'b1;
        ctl.reg_wr  = 1'b1;
        imm32       = {{20{id_idata_in[31]}}, id_idata_in[31:20]};
      end
      7'b0100011: begin
        ctl.alu_src = 2'b01;
        case (f3[1:0])
          2'b00:   ctl.dwe = 4'b0001;
          2'b01:   ctl.dwe = 4'b0011;
          default: ctl.dwe = 4'b1111;
        endcase
        imm32 = {{20{id_idata_in[31]}}, id_idata_in[31:25], id_idata_in[11:7]};
      end
      7'b1100011: begin
        ctl.branch = 2'b01;
        imm32 = {{19{id_idata_in[31]}}, id_idata_in[31], id_idata_in[7],
                 id_idata_in[30:25], id_idata_in[11:8], 1'b0};
      end
      7'b1101111: begin
        ctl.branch   = 2'b10;
        ctl.reginsel = 2'b01;
        ctl.reg_wr   = 1'b1;
        imm32 = {{11{id_idata_in[31]}}, id_idata_in[31], id_idata_in[19:12],
                 id_idata_in[20], id_idata_in[30:21], 1'b0};
      end
      7'b1100111: begin
        ctl.branch   = 2'b11;
        ctl.alu_src  = 2'b01;
        ctl.reginsel = 2'b01;
        ctl.reg_wr   = 1'b1;
        imm32 = {{20{id_idata_in[31]}}, id_idata_in[31:20]};
      end
      7'b0110111: begin
        ctl.alu_src  = 2'b01;
        ctl.reginsel = 2'b10;
        ctl.reg_wr   = 1'b1;
        imm32 = {id_idata_in[31:12], 12'b0};
      end
      7'b0010111: begin
        ctl.alu_src = 2'b11;
        ctl.reg_wr  = 1'b1;
        imm32 = {id_idata_in[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Every format carries its sign in bit 31, so a signed widen is enough.
  assign imm = XLEN'($signed(imm32));

  // Indices past NREG read as zero and are never written.
  assign rv1_raw = (int'(rs1) < NREG) ? rf[rs1[AW-1:0]] : '0;
  assign rv2_raw = (int'(rs2) < NREG) ? rf[rs2[AW-1:0]] : '0;
  assign wb_we   = wb_reg_wr_in && (wb_rd_in != 5'd0) && (int'(wb_rd_in) < NREG);

`ifdef DECODE_WB_BYPASS_EN
  assign rv1 = (wb_we && wb_rd_in == rs1) ? wb_data_in : rv1_raw;
  assign rv2 = (wb_we && wb_rd_in == rs2) ? wb_data_in : rv2_raw;
`else
  assign rv1 = rv1_raw;
  assign rv2 = rv2_raw;
`endif

  assign id_dbg_out = rf[AW'(DBG_REG)];

  // Load-use: the load in the output register has no data yet. rs fields
  // are compared for every format; a false match only costs one bubble.
  assign hazard = id_valid_out && id_ctrl_out[1] && id_ctrl_out[0] &&
                  (id_rd_out != 5'd0) && (rs1 == id_rd_out || rs2 == id_rd_out);

  assign id_ready_out = (!id_valid_out || ex_ready_in) && !hazard && !id_flush_in;
  assign load         = id_valid_in && id_ready_out;

  // Writes ignore stall and flush; only reset blocks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_rd_in[AW-1:0]] <= wb_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_out <= 1'b0;
      id_ctrl_out  <= '0;
      id_rv1_out   <= '0;
      id_rv2_out   <= '0;
      id_imm_out   <= '0;
      id_pc_out    <= '0;
      id_rd_out    <= '0;
      id_func3_out <= '0;
    end else if (id_flush_in) begin
      id_valid_out <= 1'b0;
    end else if (load) begin
      id_valid_out <= 1'b1;
      id_ctrl_out  <= ctl;
      id_rv1_out   <= rv1;
      id_rv2_out   <= rv2;
      id_imm_out   <= imm;
      id_pc_out    <= id_pc_in;
      id_rd_out    <= id_idata_in[11:7];
      id_func3_out <= f3;
    end else if (ex_ready_in) begin
      id_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int XLEN = 32;

  logic            clk, rst;
  logic            id_valid_in, id_flush_in, ex_ready_in, wb_reg_wr_in;
  logic [31:0]     id_idata_in;
  logic [XLEN-1:0] id_pc_in, wb_data_in;
  logic [4:0]      wb_rd_in;
  logic            id_ready_out, id_valid_out;
  logic [15:0]     id_ctrl_out;
  logic [XLEN-1:0] id_rv1_out, id_rv2_out, id_imm_out, id_pc_out, id_dbg_out;
  logic [4:0]      id_rd_out;
  logic [2:0]      id_func3_out;

  decode_stage #(.XLEN(XLEN), .NREG(32), .DBG_REG(31)) dut (
    .clk(clk), .rst(rst),
    .id_valid_in(id_valid_in), .id_idata_in(id_idata_in), .id_pc_in(id_pc_in),
    .id_ready_out(id_ready_out), .id_flush_in(id_flush_in), .ex_ready_in(ex_ready_in),
    .wb_reg_wr_in(wb_reg_wr_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .id_valid_out(id_valid_out), .id_ctrl_out(id_ctrl_out),
    .id_rv1_out(id_rv1_out), .id_rv2_out(id_rv2_out), .id_imm_out(id_imm_out),
    .id_pc_out(id_pc_out), .id_rd_out(id_rd_out), .id_func3_out(id_func3_out),
    .id_dbg_out(id_dbg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-assembled instruction words
  localparam logic [31:0] ADD6   = 32'h0002_8333; // add  x6,x5,x0
  localparam logic [31:0] LW7    = 32'h0000_A383; // lw   x7,0(x1)
  localparam logic [31:0] ADD8   = 32'h0023_8433; // add  x8,x7,x2
  localparam logic [31:0] SUB10  = 32'h4062_8533; // sub  x10,x5,x6
  localparam logic [31:0] ADDI11 = 32'hFFF2_8593; // addi x11,x5,-1
  localparam logic [31:0] SW     = 32'hFE53_2E23; // sw   x5,-4(x6)
  localparam logic [31:0] BEQ    = 32'hFE62_8CE3; // beq  x5,x6,-8
  localparam logic [31:0] LUI12  = 32'h1234_5637; // lui  x12,0x12345
  localparam logic [31:0] JAL1   = 32'h0010_00EF; // jal  x1,+2048
  localparam logic [31:0] ADD13  = 32'h0000_06B3; // add  x13,x0,x0
  localparam logic [31:0] LW0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD8Z  = 32'h0000_0433; // add  x8,x0,x0
  localparam logic [31:0] ADD9   = 32'h0071_04B3; // add  x9,x2,x7
  localparam logic [31:0] ADD14  = 32'h0004_8733; // add  x14,x9,x0

  typedef struct {
    logic v; logic [31:0] ins; logic exr, fl, ww; logic [4:0] wrd; logic [31:0] wd;
    logic e_rdy, e_vld, chk;
    logic [31:0] e_rv1, e_rv2, e_imm; logic [4:0] e_rd; logic [2:0] e_f3;
    logic [15:0] e_ctrl; int pc_row;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] ins, logic exr, logic fl, logic ww,
                              logic [4:0] wrd, logic [31:0] wd, logic e_rdy, logic e_vld,
                              logic chk, logic [31:0] e_rv1, logic [31:0] e_rv2,
                              logic [31:0] e_imm, logic [4:0] e_rd, logic [2:0] e_f3,
                              logic [15:0] e_ctrl, int pc_row);
    vec_t r;
    r.v = v; r.ins = ins; r.exr = exr; r.fl = fl; r.ww = ww; r.wrd = wrd; r.wd = wd;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.chk = chk; r.e_rv1 = e_rv1; r.e_rv2 = e_rv2;
    r.e_imm = e_imm; r.e_rd = e_rd; r.e_f3 = e_f3; r.e_ctrl = e_ctrl; r.pc_row = pc_row;
    return r;
  endfunction

  localparam int NV = 21;
  vec_t vt [NV];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic exr,
                       input logic fl, input logic ww, input logic [4:0] wrd,
                       input logic [31:0] wd);
    id_valid_in = v; id_idata_in = ins; ex_ready_in = exr; id_flush_in = fl;
    wb_reg_wr_in = ww; wb_rd_in = wrd; wb_data_in = wd;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    //            v ins    exr fl ww rd  wdata        rdy vld chk rv1          rv2      imm           rd f3 ctrl     pc
    vt[0]  = mk(0, 0,      1, 0, 1, 5,  32'h1234,    1, 0, 0, 0,           0,       0,            0, 0, 16'h0,   0);
    vt[1]  = mk(1, ADD6,   1, 0, 1, 1,  32'h100,     1, 1, 1, 32'h1234,    0,       0,            6, 0, 16'h0001, 1);
    vt[2]  = mk(1, LW7,    1, 0, 1, 2,  32'h22,      1, 1, 1, 32'h100,     0,       0,            7, 2, 16'h4003, 2);
    vt[3]  = mk(1, ADD8,   1, 0, 1, 7,  32'h77,      0, 0, 0, 0,           0,       0,            0, 0, 16'h0,   0);
    vt[4]  = mk(1, ADD8,   1, 0, 0, 0,  0,           1, 1, 1, 32'h77,      32'h22,  0,            8, 0, 16'h0001, 4);
    vt[5]  = mk(1, SUB10,  0, 0, 1, 6,  32'h10,      0, 1, 1, 32'h77,      32'h22,  0,            8, 0, 16'h0001, 4);
    vt[6]  = mk(1, SUB10,  0, 0, 0, 0,  0,           0, 1, 1, 32'h77,      32'h22,  0,            8, 0, 16'h0001, 4);
    vt[7]  = mk(1, SUB10,  0, 0, 0, 0,  0,           0, 1, 1, 32'h77,      32'h22,  0,            8, 0, 16'h0001, 4);
    vt[8]  = mk(1, SUB10,  1, 0, 0, 0,  0,           1, 1, 1, 32'h1234,    32'h10,  0,           10, 0, 16'h2001, 8);
    vt[9]  = mk(1, ADDI11, 0, 1, 0, 0,  0,           0, 0, 1, 32'h1234,    32'h10,  0,           10, 0, 16'h2001, 8);
    vt[10] = mk(1, ADDI11, 1, 0, 0, 0,  0,           1, 1, 1, 32'h1234,    0,       32'hFFFFFFFF,11, 0, 16'h4001, 10);
    vt[11] = mk(1, SW,     1, 0, 1, 31, 32'hCAFE,    1, 1, 1, 32'h10,      32'h1234,32'hFFFFFFFC,28, 2, 16'h403C, 11);
    vt[12] = mk(1, BEQ,    1, 0, 1, 0,  32'hDEAD,    1, 1, 1, 32'h1234,    32'h10,  32'hFFFFFFF8,25, 0, 16'h0100, 12);
    vt[13] = mk(1, LUI12,  1, 0, 0, 0,  0,           1, 1, 1, 0,           0,       32'h12345000,12, 5, 16'h4081, 13);
    vt[14] = mk(1, JAL1,   1, 0, 0, 0,  0,           1, 1, 1, 0,           32'h100, 32'h800,      1, 0, 16'h0241, 14);
    vt[15] = mk(1, ADD13,  1, 0, 0, 0,  0,           1, 1, 1, 0,           0,       0,           13, 0, 16'h0001, 15);
    vt[16] = mk(1, LW0,    1, 0, 0, 0,  0,           1, 1, 1, 32'h100,     0,       0,            0, 2, 16'h4003, 16);
    vt[17] = mk(1, ADD8Z,  1, 0, 0, 0,  0,           1, 1, 1, 0,           0,       0,            8, 0, 16'h0001, 17);
    vt[18] = mk(1, LW7,    1, 0, 0, 0,  0,           1, 1, 1, 32'h100,     0,       0,            7, 2, 16'h4003, 18);
    vt[19] = mk(1, ADD9,   1, 0, 0, 0,  0,           0, 0, 0, 0,           0,       0,            0, 0, 16'h0,   0);
    vt[20] = mk(1, ADD9,   1, 0, 0, 0,  0,           1, 1, 1, 32'h22,      32'h77,  0,            9, 0, 16'h0001, 20);

    // Reset
    rst = 1'b1; id_pc_in = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst valid", id_valid_out, 0);
    chk("rst ctrl",  id_ctrl_out, 0);
    chk("rst rv1",   id_rv1_out, 0);
    chk("rst imm",   id_imm_out, 0);
    chk("rst ready", id_ready_out, 1);
    chk("rst dbg",   id_dbg_out, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].ins, vt[i].exr, vt[i].fl, vt[i].ww, vt[i].wrd, vt[i].wd);
      id_pc_in = 32'h1000 + 32'(i * 4);
      #1;
      chk($sformatf("r%0d ready", i), id_ready_out, vt[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("r%0d valid", i), id_valid_out, vt[i].e_vld);
      if (vt[i].chk) begin
        chk($sformatf("r%0d rv1", i),  id_rv1_out,   vt[i].e_rv1);
        chk($sformatf("r%0d rv2", i),  id_rv2_out,   vt[i].e_rv2);
        chk($sformatf("r%0d imm", i),  id_imm_out,   vt[i].e_imm);
        chk($sformatf("r%0d rd", i),   id_rd_out,    vt[i].e_rd);
        chk($sformatf("r%0d f3", i),   id_func3_out, vt[i].e_f3);
        chk($sformatf("r%0d ctrl", i), id_ctrl_out,  vt[i].e_ctrl);
        chk($sformatf("r%0d pc", i),   id_pc_out,    32'h1000 + 32'(vt[i].pc_row * 4));
      end
    end

    chk("dbg x31", id_dbg_out, 32'hCAFE);

    // Same-cycle writeback and read of x9
`ifdef DECODE_WB_BYPASS_EN
    bypass_exp = 32'hBEEF;
`else
    bypass_exp = 32'h1111;
`endif
    @(negedge clk); drive(0, 0, 1, 0, 1, 9, 32'h1111);
    @(negedge clk); drive(1, ADD14, 1, 0, 1, 9, 32'hBEEF);
    @(posedge clk); #1;
    chk("raw x9 rv1", id_rv1_out, bypass_exp);
    chk("raw x9 rd",  id_rd_out, 14);
    @(negedge clk); drive(1, ADD14, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("x9 after wr", id_rv1_out, 32'hBEEF);
    // Same-cycle write to x0 never shows up, bypass or not
    @(negedge clk); drive(1, ADD13, 1, 0, 1, 0, 32'h5);
    @(posedge clk); #1;
    chk("x0 wr rv1", id_rv1_out, 0);
    chk("x0 wr rv2", id_rv2_out, 0);

    // Reset beats flush, load and write
    @(negedge clk); rst = 1'b1; drive(1, ADD14, 1, 1, 1, 9, 32'h4444);
    @(posedge clk); #1;
    chk("rst2 valid", id_valid_out, 0);
    chk("rst2 ctrl",  id_ctrl_out, 0);
    chk("rst2 rd",    id_rd_out, 0);
    chk("rst2 pc",    id_pc_out, 0);
    chk("rst2 dbg",   id_dbg_out, 0);
    @(negedge clk); rst = 1'b0; drive(1, ADD14, 1, 0, 0, 0, 0);
    #1;
    chk("rst2 ready", id_ready_out, 1);
    @(posedge clk); #1;
    chk("rst2 x9 cleared", id_rv1_out, 0);
    chk("rst2 load valid", id_valid_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
